// File: rtl/bram1_be_req_server.sv
// Valid/ready request front end for a single-port byte-enabled BRAM.
// Tracks reads across the BRAM latency and returns DO through a credit-protected response FIFO.
module bram1_be_req_server #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int WE_WIDTH   = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WE_WIDTH-1:0]   req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  bram_en,
  output logic [WE_WIDTH-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int LAT = 1 + PIPELINED;
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

  logic                  r_live;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_fcnt;
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [LAT-1:0]        r_pipe;
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];

  logic w_fire;
  logic w_rd_fire;
  logic w_pop;
  logic w_push;

  // Handshakes: a request transfers when req_valid & req_ready are high at a rising
  // edge (fire); a response transfers when rsp_valid & rsp_ready are high (pop).
  // req_ready never looks at req_valid, and rsp_valid/rsp_data never look at rsp_ready.
  assign rsp_valid = (r_fcnt != '0);
  assign w_pop     = rsp_valid & rsp_ready;
  assign req_ready = RST_N & r_live & ((r_cnt < DEPTH_C) | w_pop);
  assign w_fire    = req_valid & req_ready;
  assign w_rd_fire = w_fire & ~(|req_we);
  assign w_push    = r_pipe[LAT-1];

  assign bram_en   = w_fire;
  assign bram_we   = w_fire ? req_we : '0;
  assign bram_addr = req_addr;
  assign bram_di   = req_data;
  assign rsp_data  = r_mem[r_rd];

  // r_cnt holds read credits (in flight plus stored); r_fcnt holds FIFO occupancy only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_live <= 1'b0;
      r_cnt  <= '0;
      r_fcnt <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_pipe <= '0;
    end else begin
      r_live <= 1'b1;
      r_pipe <= (r_pipe << 1) | LAT'(w_rd_fire);
      if (w_rd_fire && !w_pop)      r_cnt <= r_cnt + ONE_C;
      else if (!w_rd_fire && w_pop) r_cnt <= r_cnt - ONE_C;
      if (w_push && !w_pop)         r_fcnt <= r_fcnt + ONE_C;
      else if (!w_push && w_pop)    r_fcnt <= r_fcnt - ONE_C;
      if (w_push) r_wr <= (r_wr == LAST_C) ? '0 : r_wr + PW'(1);
      if (w_pop)  r_rd <= (r_rd == LAST_C) ? '0 : r_rd + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= bram_do;
  end

`ifndef SYNTHESIS
  // Credit accounting makes a push into a full FIFO without a pop unreachable.
  always @(posedge CLK) begin
    if (RST_N) assert (!(w_push && !w_pop && (r_fcnt == DEPTH_C)));
  end
`endif

endmodule

// File: tb/tb_bram1_be_req_server.sv
// Bench for bram1_be_req_server: three DUT configurations, each with a behavioural BRAM,
// driven through one selectable stimulus port and checked against a memory/queue model.
module tb_bram1_be_req_server;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [3:0]  req_we = '0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  sel = '0;

  always #5 CLK = ~CLK;

  logic [2:0]  rdy_v, vld_v, en_v;
  logic [31:0] rdata_v [3];
  logic [31:0] di_v [3];
  logic [31:0] do_v [3];
  logic [3:0]  we_v [3];
  logic [3:0]  addr_v [3];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] ref_mem [3][16];

  // Instance 0: LAT=1 depth 4; instance 1: LAT=2 depth 3 (LAT+1); instance 2: LAT=2 depth 8.
  for (genvar g = 0; g < 3; g++) begin : g_d
    localparam int PIPE = (g == 0) ? 0 : 1;
    localparam int DEP  = (g == 0) ? 4 : ((g == 1) ? 3 : 8);
    logic [31:0] mem [16];
    logic [31:0] do1, do2;

    always @(posedge CLK) begin
      if (en_v[g]) begin
        do1 <= mem[addr_v[g]];
        for (int k = 0; k < 4; k++)
          if (we_v[g][k]) mem[addr_v[g]][8*k +: 8] <= di_v[g][8*k +: 8];
      end
      do2 <= do1;
    end
    assign do_v[g] = (PIPE != 0) ? do2 : do1;

    bram1_be_req_server #(
      .PIPELINED (PIPE),
      .ADDR_WIDTH(4),
      .DATA_WIDTH(32),
      .WE_WIDTH  (4),
      .RSP_DEPTH (DEP)
    ) u_dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .req_valid(req_valid && (sel == 2'(g))),
      .req_ready(rdy_v[g]),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_data (req_data),
      .rsp_valid(vld_v[g]),
      .rsp_ready(rsp_ready && (sel == 2'(g))),
      .rsp_data (rdata_v[g]),
      .bram_en  (en_v[g]),
      .bram_we  (we_v[g]),
      .bram_addr(addr_v[g]),
      .bram_di  (di_v[g]),
      .bram_do  (do_v[g])
    );
  end

  logic        s_ready, s_valid, s_en;
  logic [31:0] s_data, s_di;
  logic [3:0]  s_we, s_addr;
  int          s_cnt;
  assign s_ready = rdy_v[sel];
  assign s_valid = vld_v[sel];
  assign s_en    = en_v[sel];
  assign s_data  = rdata_v[sel];
  assign s_di    = di_v[sel];
  assign s_we    = we_v[sel];
  assign s_addr  = addr_v[sel];

  always_comb begin
    s_cnt = 0;
    case (sel)
      2'd0:    s_cnt = 32'(g_d[0].u_dut.r_cnt);
      2'd1:    s_cnt = 32'(g_d[1].u_dut.r_cnt);
      default: s_cnt = 32'(g_d[2].u_dut.r_cnt);
    endcase
  end

  function automatic int depth_of(input logic [1:0] s);
    return (s == 2'd0) ? 4 : ((s == 2'd1) ? 3 : 8);
  endfunction

  // One clock cycle on the selected DUT; the model records every accepted request.
  task automatic drive_cycle(input logic v, input logic [3:0] we, input logic [3:0] addr,
                             input logic [31:0] data, input logic rr,
                             output logic fired, output logic popped,
                             output logic [31:0] pdata, output logic [40:0] pins);
    req_valid = v; req_we = we; req_addr = addr; req_data = data; rsp_ready = rr;
    @(negedge CLK);
    fired  = v & s_ready;
    popped = s_valid & rr;
    pdata  = s_data;
    pins   = {s_en, s_we, s_addr, s_di};
    if (fired) begin
      if (we == 4'h0) exp_q.push_back(ref_mem[sel][addr]);
      else for (int k = 0; k < 4; k++)
        if (we[k]) ref_mem[sel][addr][8*k +: 8] = data[8*k +: 8];
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    exp_q.delete();
  endtask

  task automatic prefill();
    logic f, p; logic [31:0] d; logic [40:0] pins;
    for (int a = 0; a < 16; a++) drive_cycle(1'b1, 4'hF, 4'(a), $urandom, 1'b0, f, p, d, pins);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; req_valid = 1'b1; req_we = 4'h0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready sel=%0d got=%b exp=0", s, s_ready); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid sel=%0d got=%b exp=0", s, s_valid); end
      checks++; if (s_en !== 1'b0) begin errors++; $display("FAIL reset_en sel=%0d got=%b exp=0", s, s_en); end
    end
    req_valid = 1'b0;
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_ready sel=%0d got=%b exp=1", s, s_ready); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL release_valid sel=%0d got=%b exp=0", s, s_valid); end
    end
  endtask

  task automatic test_write_read_lat();
    logic f, p, got, idle_en; logic [31:0] d; logic [40:0] pins; int k;
    sel = 2'd0; do_reset();
    drive_cycle(1'b1, 4'hF, 4'd3, 32'h0, 1'b1, f, p, d, pins);
    drive_cycle(1'b1, 4'h1, 4'd3, 32'hA5, 1'b1, f, p, d, pins);
    checks++; if (pins !== {1'b1, 4'h1, 4'd3, 32'hA5})
      begin errors++; $display("FAIL write_pins got=%h exp=%h", pins, {1'b1, 4'h1, 4'd3, 32'hA5}); end
    drive_cycle(1'b1, 4'h0, 4'd3, 32'h0, 1'b1, f, p, d, pins);
    checks++; if (pins[40:32] !== {1'b1, 4'h0, 4'd3} || f !== 1'b1)
      begin errors++; $display("FAIL read_pins got=%h fired=%b exp=%h", pins[40:32], f, {1'b1, 4'h0, 4'd3}); end
    k = 0; got = 1'b0; idle_en = 1'b0;
    while (!got && k < 10) begin
      k++;
      drive_cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, f, p, d, pins);
      if (k == 1) idle_en = pins[40];
      if (p) got = 1'b1;
    end
    checks++; if (idle_en !== 1'b0) begin errors++; $display("FAIL idle_en got=%b exp=0", idle_en); end
    checks++; if (!got || k != 2) begin errors++; $display("FAIL lat_unpiped got=%0d exp=2 seen=%b", k, got); end
    checks++; if (d !== 32'h000000A5) begin errors++; $display("FAIL data_unpiped got=%h exp=000000a5", d); end
  endtask

  task automatic test_pipelined_be();
    logic f, p, got; logic [31:0] d; logic [40:0] pins; int k;
    sel = 2'd1; do_reset();
    drive_cycle(1'b1, 4'hF, 4'd0, 32'h11223344, 1'b1, f, p, d, pins);
    drive_cycle(1'b1, 4'b0010, 4'd0, 32'hFFFFFFFF, 1'b1, f, p, d, pins);
    drive_cycle(1'b1, 4'h0, 4'd0, 32'h0, 1'b1, f, p, d, pins);
    k = 0; got = 1'b0;
    while (!got && k < 10) begin
      k++;
      drive_cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, f, p, d, pins);
      if (p) got = 1'b1;
    end
    checks++; if (!got || k != 3) begin errors++; $display("FAIL lat_piped got=%0d exp=3 seen=%b", k, got); end
    checks++; if (d !== 32'h1122FF44) begin errors++; $display("FAIL data_be got=%h exp=1122ff44", d); end
  endtask

  task automatic test_backpressure();
    logic f, p; logic [31:0] d, e; logic [40:0] pins; int acc, pops, n;
    sel = 2'd0; do_reset(); prefill();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 4'h0, 4'(acc), 32'h0, 1'b0, f, p, d, pins);
      if (f) acc++;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    checks++; if (pins[40] !== 1'b0) begin errors++; $display("FAIL bp_en_blocked got=%b exp=0", pins[40]); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", s_ready); end
    checks++; if (s_cnt != 4) begin errors++; $display("FAIL bp_cnt got=%0d exp=4", s_cnt); end
    pops = 0; n = 0;
    while (pops < 6 && n < 40) begin
      n++;
      drive_cycle(acc < 6, 4'h0, 4'(acc), 32'h0, 1'b1, f, p, d, pins);
      if (f) acc++;
      if (p) begin
        pops++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra got=%h exp=none", d); end
        else begin e = exp_q.pop_front();
          if (d !== e) begin errors++; $display("FAIL bp_data idx=%0d got=%h exp=%h", pops - 1, d, e); end
        end
      end
    end
    checks++; if (pops != 6 || exp_q.size() != 0)
      begin errors++; $display("FAIL bp_count got=%0d exp=6 left=%0d", pops, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic f, p; logic [31:0] d, e; logic [40:0] pins; int drops, pops, n;
    sel = 2'd1; do_reset(); prefill();
    drops = 0; pops = 0;
    for (int i = 0; i < 64 + 10; i++) begin
      drive_cycle(i < 64, 4'h0, 4'(i % 16), 32'h0, 1'b1, f, p, d, pins);
      if (i < 64 && !f) drops++;
      if (p) begin
        pops++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra got=%h exp=none", d); end
        else begin e = exp_q.pop_front();
          if (d !== e) begin errors++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", pops - 1, d, e); end
        end
      end
    end
    n = drops;
    checks++; if (n != 0) begin errors++; $display("FAIL b2b_ready_drops got=%0d exp=0", n); end
    checks++; if (pops != 64) begin errors++; $display("FAIL b2b_count got=%0d exp=64", pops); end
  endtask

  task automatic test_random();
    logic f, p, v, rr; logic [31:0] d, e; logic [40:0] pins; logic [3:0] we; int outst, n;
    for (int s = 0; s < 3; s += 2) begin
      sel = 2'(s); do_reset(); prefill();
      outst = 0;
      for (int i = 0; i < 400 + 60; i++) begin
        checks++; if (s_cnt != outst) begin errors++; $display("FAIL rnd_cnt sel=%0d cyc=%0d got=%0d exp=%0d", s, i, s_cnt, outst); end
        checks++; if (s_cnt > depth_of(sel)) begin errors++; $display("FAIL rnd_cnt_max sel=%0d got=%0d exp<=%0d", s, s_cnt, depth_of(sel)); end
        v  = (i < 400) && ($urandom_range(0, 9) < 7);
        we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        rr = (i >= 400) || ($urandom_range(0, 1) == 1);
        drive_cycle(v, we, 4'($urandom), $urandom, rr, f, p, d, pins);
        if (f && we == 4'h0) outst++;
        if (p) begin
          outst--; checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra sel=%0d got=%h exp=none", s, d); end
          else begin e = exp_q.pop_front();
            if (d !== e) begin errors++; $display("FAIL rnd_data sel=%0d cyc=%0d got=%h exp=%h", s, i, d, e); end
          end
        end
      end
      n = exp_q.size();
      checks++; if (n != 0 || s_valid !== 1'b0)
        begin errors++; $display("FAIL rnd_drain sel=%0d left=%0d valid=%b exp=0", s, n, s_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic f, p; logic [31:0] d; logic [40:0] pins; int stale;
    sel = 2'd2; do_reset(); prefill();
    drive_cycle(1'b1, 4'h0, 4'd1, 32'h0, 1'b0, f, p, d, pins);
    drive_cycle(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, f, p, d, pins);
    repeat (4) drive_cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, f, p, d, pins);
    drive_cycle(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, f, p, d, pins);
    drive_cycle(1'b1, 4'h0, 4'd4, 32'h0, 1'b0, f, p, d, pins);
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL mid_stored_valid got=%b exp=1", s_valid); end
    req_valid = 1'b1; req_we = 4'h0; req_addr = 4'd5; rsp_ready = 1'b1;
    #2 RST_N = 1'b0; #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", s_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", s_ready); end
    checks++; if (s_en !== 1'b0) begin errors++; $display("FAIL mid_en got=%b exp=0", s_en); end
    repeat (2) @(posedge CLK);
    req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got=%b exp=1", s_ready); end
    exp_q.delete();
    stale = 0;
    repeat (10) begin
      drive_cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, f, p, d, pins);
      if (p) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read_lat();
    test_pipelined_be();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
